// File: rtl/binary_bcd_serial_converter_pkg.sv
// Shared types and constants for the serial double-dabble converter.
package binary_bcd_serial_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // 10^n, used to prove at elaboration that DIGITS can hold the largest operand.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/binary_bcd_serial_converter_bcd_digit_adjust.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal digit.
module binary_bcd_serial_converter_bcd_digit_adjust
  import binary_bcd_serial_converter_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Only 0..9 reach this cell, so the 4-bit sum never wraps.
  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/binary_bcd_serial_converter.sv
// Multi-cycle binary-to-BCD converter: one correct/shift step per clock,
// valid/ready on both sides, leading-zero mask delivered with each result.
//
//   state  | meaning
//   IDLE   | waiting for an operand (in_ready = 1)
//   SHIFT  | one double-dabble step per cycle, counter counts down
//   DONE   | result held on bcd_out/digit_mask until out_ready
module binary_bcd_serial_converter
  import binary_bcd_serial_converter_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3,
  parameter int CNT_W     = $clog2(BIN_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_mask,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  if (BIN_WIDTH < 4 || BIN_WIDTH > 32) begin : g_bad_width
    $error("binary_bcd_serial_converter: BIN_WIDTH must be within 4..32");
  end

  if (pow10(DIGITS) <= ((64'd1 << BIN_WIDTH) - 64'd1)) begin : g_bad_digits
    $error("binary_bcd_serial_converter: DIGITS too small for BIN_WIDTH");
  end

  state_t                 r_state;
  logic [BIN_WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [BCD_W-1:0]       r_bcd_out;
  logic [DIGITS-1:0]      r_mask;
  logic                   r_out_valid;
  logic                   r_busy;

  logic [BCD_W-1:0]           w_adj;
  logic [BCD_W+BIN_WIDTH-1:0] w_cat_shift;
  logic [BCD_W-1:0]           w_acc_next;
  logic [BIN_WIDTH-1:0]       w_bin_next;
  logic [DIGITS-1:0]          w_mask;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    binary_bcd_serial_converter_bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*d +: 4]),
      .o_digit (w_adj[4*d +: 4])
    );
  end

  // Correct first, then shift the whole {accumulator, operand} pair left by one.
  assign w_cat_shift = {w_adj, r_bin} << 1;
  assign w_acc_next  = w_cat_shift[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
  assign w_bin_next  = w_cat_shift[BIN_WIDTH-1:0];

  // Leading-zero mask of the value about to be latched: a digit is significant
  // if it or any more significant digit is nonzero; units is always shown.
  always_comb begin
    logic w_any;
    w_any  = 1'b0;
    w_mask = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_any     = w_any | (|w_acc_next[4*d +: 4]);
      w_mask[d] = w_any;
    end
    w_mask[0] = 1'b1;
  end

  // Control FSM with registered outputs; the final shift result is captured on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bcd_out   <= '0;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_bin   <= bin_in;
            r_acc   <= '0;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bin <= w_bin_next;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_bcd_out   <= w_acc_next;
            r_mask      <= w_mask;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign bcd_out    = r_bcd_out;
  assign digit_mask = r_mask;

endmodule
